// File: rtl/bus_steal.sv
// bus_steal: drives BA/AEC, giving the CPU a 3-cycle BA warning before stealing phase 2 for sprite and c-access DMA.
// Optional BUS_STEAL_STATS_EN adds stolen_last, the count of phase-2 steals in the previous raster line.
module bus_steal #(
  parameter int NUM_SPRITES = 8,
  parameter int LOOKAHEAD = 3
) (
  input  logic                   clk_dot4x,
  input  logic                   rst,
  input  logic                   clk_phi,
  input  logic                   phi_phase_start_1,
  input  logic [1:0]             chip,
  input  logic [6:0]             cycle_num,
  input  logic [NUM_SPRITES-1:0] sprite_dma,
  input  logic                   badline,
  output logic                   ba,
  output logic                   aec,
`ifdef BUS_STEAL_STATS_EN
  output logic                   steal,
  output logic [6:0]             stolen_last
`else
  output logic                   steal
`endif
);
  localparam logic [1:0] CHIP6567R8 = 2'd0;
  localparam logic [1:0] CHIP6569R5 = 2'd1;
  localparam logic [1:0] CHIP6567R56A = 2'd2;
  localparam logic [1:0] CHIP6569R1 = 2'd3;
  function automatic logic [7:0] wrap(input logic [7:0] x, input logic [7:0] len);
    return x >= len ? x - len : x;
  endfunction
  function automatic logic stolen_f(input logic [7:0] n, input logic [7:0] len, input logic [7:0] s0,
                                    input logic [NUM_SPRITES-1:0] dma, input logic bad);
    logic hit;
    logic [7:0] f;
    hit = bad && n >= 8'd14 && n <= 8'd53;
    for (int s = 0; s < NUM_SPRITES; s++) begin
      f = wrap(s0 + 8'(2 * s), len);
      hit = hit | (dma[s] && (n == f || n == wrap(f + 8'd1, len)));
    end
    return hit;
  endfunction
  logic [7:0] line_len, s0, cyc8;
  logic       bnd, p2, req, stolen_now, grant;
  logic       ba_q, ba_d, aec_q, aec_d, steal_q, steal_d;
  logic [1:0] ba_cnt_q, ba_cnt_d;
  always_comb begin
    line_len = chip == CHIP6567R8 ? 8'd65 : chip == CHIP6567R56A ? 8'd64 : 8'd63;
    s0 = (chip == CHIP6569R5 || chip == CHIP6569R1) ? 8'd57 : 8'd58;
    cyc8 = {1'b0, cycle_num};
    bnd = phi_phase_start_1 && clk_phi;
    p2 = phi_phase_start_1 && !clk_phi;
    req = 1'b0;
    for (int k = 0; k <= LOOKAHEAD; k++)
      req = req | stolen_f(wrap(cyc8 + 8'(k), line_len), line_len, s0, sprite_dma, badline);
    stolen_now = stolen_f(wrap(cyc8, line_len), line_len, s0, sprite_dma, badline);
    // the CPU must have seen BA low for three full cycles before its bus is taken
    grant = stolen_now && ba_cnt_q == 2'd3;
    ba_d = bnd ? !req : ba_q;
    aec_d = bnd ? 1'b0 : p2 ? !grant : aec_q;
    steal_d = bnd ? 1'b0 : p2 ? grant : steal_q;
    ba_cnt_d = !bnd ? ba_cnt_q : !req ? 2'd0 : ba_cnt_q == 2'd3 ? 2'd3 : ba_cnt_q + 2'd1;
  end
  always_ff @(posedge clk_dot4x) begin
    if (rst) begin
      ba_q <= 1'b1;
      aec_q <= 1'b0;
      steal_q <= 1'b0;
      ba_cnt_q <= 2'd0;
    end else begin
      ba_q <= ba_d;
      aec_q <= aec_d;
      steal_q <= steal_d;
      ba_cnt_q <= ba_cnt_d;
    end
  end
  assign ba = ba_q;
  assign aec = aec_q;
  assign steal = steal_q;
`ifdef BUS_STEAL_STATS_EN
  logic [6:0] cnt_q, cnt_d, last_q, last_d;
  logic       line_end;
  always_comb begin
    line_end = bnd && cyc8 == line_len - 8'd1;
    cnt_d = line_end ? 7'd0 : (p2 && grant) ? cnt_q + 7'd1 : cnt_q;
    last_d = line_end ? cnt_q : last_q;
  end
  always_ff @(posedge clk_dot4x) begin
    if (rst) begin
      cnt_q <= 7'd0;
      last_q <= 7'd0;
    end else begin
      cnt_q <= cnt_d;
      last_q <= last_d;
    end
  end
  assign stolen_last = last_q;
`endif
endmodule

// File: tb/tb_bus_steal.sv
// tb_bus_steal: table checkpoints, hand corner sequences and randomized lines against a cycle-level model of bus_steal.
module tb_bus_steal;
  logic       clk_dot4x = 1'b0;
  logic       rst = 1'b1;
  logic       clk_phi = 1'b0;
  logic       phi_phase_start_1 = 1'b0;
  logic [1:0] chip = 2'd1;
  logic [6:0] cycle_num = 7'd0;
  logic [7:0] sprite_dma = 8'h00;
  logic       badline = 1'b0;
  logic       ba, aec, steal;
`ifdef BUS_STEAL_STATS_EN
  logic [6:0] stolen_last;
`endif
  int compared = 0;
  int mismatched = 0;
  int run = 0;
  int steals = 0;
  int exp_last = 0;

  bus_steal dut (
    .clk_dot4x(clk_dot4x), .rst(rst), .clk_phi(clk_phi), .phi_phase_start_1(phi_phase_start_1),
    .chip(chip), .cycle_num(cycle_num), .sprite_dma(sprite_dma), .badline(badline),
`ifdef BUS_STEAL_STATS_EN
    .stolen_last(stolen_last),
`endif
    .ba(ba), .aec(aec), .steal(steal)
  );

  always #5 clk_dot4x = ~clk_dot4x;

  typedef struct {
    logic [1:0] chip;
    logic [7:0] dma;
    logic       bad;
    int         cyc;
    logic       ba;
    logic       aec;
  } row_t;
  row_t tbl[22];

  function automatic int len_of(input logic [1:0] c);
    return c == 2'd0 ? 65 : c == 2'd2 ? 64 : 63;
  endfunction

  function automatic bit m_stolen(input int n);
    int l, b, f;
    l = len_of(chip);
    b = (chip == 2'd1 || chip == 2'd3) ? 57 : 58;
    for (int s = 0; s < 8; s++) begin
      f = (b + 2 * s) % l;
      if (sprite_dma[s] && (n == f || n == (f + 1) % l)) return 1'b1;
    end
    return badline && n >= 14 && n <= 53;
  endfunction

  function automatic bit m_req(input int n);
    for (int k = 0; k <= 3; k++)
      if (m_stolen((n + k) % len_of(chip))) return 1'b1;
    return 1'b0;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d (chip %0d cycle %0d)", name, act, exp, chip, cycle_num);
    end
  endtask

  task automatic tick(input logic phi);
    @(negedge clk_dot4x);
    clk_phi = phi;
    phi_phase_start_1 = 1'b1;
    @(negedge clk_dot4x);
    phi_phase_start_1 = 1'b0;
    clk_phi = ~phi;
    repeat (2) @(negedge clk_dot4x);
  endtask

  task automatic do_reset();
    @(negedge clk_dot4x);
    rst = 1'b1;
    clk_phi = 1'b0;
    phi_phase_start_1 = 1'b0;
    repeat (2) @(negedge clk_dot4x);
    rst = 1'b0;
    run = 0;
    steals = 0;
    exp_last = 0;
    check("reset_ba", ba, 1);
    check("reset_aec", aec, 0);
    check("reset_steal", steal, 0);
  endtask

  task automatic do_p2(input int n);
    bit s;
    cycle_num = 7'(n);
    s = m_stolen(n) && run >= 3;
    tick(1'b0);
    check("p2_aec", aec, !s);
    check("p2_steal", steal, s);
    if (s) steals++;
  endtask

  task automatic do_bnd(input int n);
    bit r;
    cycle_num = 7'(n);
    r = m_req(n);
    tick(1'b1);
    run = r ? run + 1 : 0;
    check("bnd_ba", ba, !r);
    check("bnd_aec", aec, 0);
    check("bnd_steal", steal, 0);
    if (n == len_of(chip) - 1) begin
      exp_last = steals;
      steals = 0;
    end
`ifdef BUS_STEAL_STATS_EN
    check("stolen_last", stolen_last, exp_last);
`endif
  endtask

  task automatic do_cycle(input int n);
    do_p2(n);
    do_bnd(n);
  endtask

  initial begin
    tbl = '{
      '{2'd1, 8'h01, 1'b0, 53, 1'b1, 1'b1}, '{2'd1, 8'h01, 1'b0, 54, 1'b0, 1'b1},
      '{2'd1, 8'h01, 1'b0, 57, 1'b0, 1'b0}, '{2'd1, 8'h01, 1'b0, 58, 1'b0, 1'b0},
      '{2'd1, 8'h01, 1'b0, 59, 1'b1, 1'b1},
      '{2'd1, 8'h00, 1'b1, 10, 1'b1, 1'b1}, '{2'd1, 8'h00, 1'b1, 11, 1'b0, 1'b1},
      '{2'd1, 8'h00, 1'b1, 13, 1'b0, 1'b1}, '{2'd1, 8'h00, 1'b1, 14, 1'b0, 1'b0},
      '{2'd1, 8'h00, 1'b1, 53, 1'b0, 1'b0}, '{2'd1, 8'h00, 1'b1, 54, 1'b1, 1'b1},
      '{2'd2, 8'h08, 1'b0, 60, 1'b1, 1'b1}, '{2'd2, 8'h08, 1'b0, 61, 1'b0, 1'b1},
      '{2'd2, 8'h08, 1'b0, 0, 1'b0, 1'b0},  '{2'd2, 8'h08, 1'b0, 1, 1'b0, 1'b0},
      '{2'd2, 8'h08, 1'b0, 2, 1'b1, 1'b1},
      '{2'd0, 8'hFF, 1'b0, 54, 1'b1, 1'b1}, '{2'd0, 8'hFF, 1'b0, 55, 1'b0, 1'b1},
      '{2'd0, 8'hFF, 1'b0, 58, 1'b0, 1'b0}, '{2'd0, 8'hFF, 1'b0, 64, 1'b0, 1'b0},
      '{2'd0, 8'hFF, 1'b0, 8, 1'b0, 1'b0},  '{2'd0, 8'hFF, 1'b0, 9, 1'b1, 1'b1}
    };
    for (int i = 0; i < 22; i++) begin
      chip = tbl[i].chip;
      sprite_dma = tbl[i].dma;
      badline = tbl[i].bad;
      do_reset();
      for (int n = 0; n < len_of(chip); n++) do_cycle(n);
      for (int n = 0; n <= tbl[i].cyc; n++) begin
        do_p2(n);
        if (n == tbl[i].cyc) check("tbl_aec", aec, tbl[i].aec);
        do_bnd(n);
        if (n == tbl[i].cyc) check("tbl_ba", ba, tbl[i].ba);
      end
`ifdef BUS_STEAL_STATS_EN
      if (i == 5) check("tbl_stolen_last", stolen_last, 40);
`endif
    end
    // badline appears between the phase-2 start and the boundary of cycle 30
    chip = 2'd1;
    sprite_dma = 8'h00;
    badline = 1'b0;
    do_reset();
    for (int n = 0; n < 30; n++) do_cycle(n);
    do_p2(30);
    check("mid_aec30", aec, 1);
    badline = 1'b1;
    do_bnd(30);
    check("mid_ba30", ba, 0);
    do_p2(31);
    check("mid_aec31", aec, 1);
    do_bnd(31);
    do_p2(32);
    check("mid_aec32", aec, 1);
    do_bnd(32);
    do_p2(33);
    check("mid_aec33", aec, 0);
    check("mid_steal33", steal, 1);
    do_bnd(33);
    // reset lands while phase 2 is stolen
    do_reset();
    for (int n = 0; n < 20; n++) do_cycle(n);
    do_p2(20);
    check("rs_steal_before", steal, 1);
    @(negedge clk_dot4x);
    rst = 1'b1;
    @(negedge clk_dot4x);
    rst = 1'b0;
    run = 0;
    steals = 0;
    exp_last = 0;
    check("rs_ba", ba, 1);
    check("rs_aec", aec, 0);
    check("rs_steal", steal, 0);
    do_bnd(20);
    do_p2(21);
    check("rs_aec21", aec, 1);
    do_bnd(21);
    do_p2(22);
    check("rs_aec22", aec, 1);
    do_bnd(22);
    do_p2(23);
    check("rs_aec23", aec, 0);
    do_bnd(23);
    // randomized lines with occasional badline flips mid-line
    for (int it = 0; it < 6; it++) begin
      chip = 2'($urandom_range(0, 3));
      do_reset();
      for (int ln = 0; ln < 3; ln++) begin
        sprite_dma = 8'($urandom);
        badline = 1'($urandom_range(0, 1));
        for (int n = 0; n < len_of(chip); n++) begin
          if ($urandom_range(0, 15) == 0) badline = ~badline;
          do_cycle(n);
        end
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/bus_steal.md
Name: bus_steal

Overview:
- Counterpart to the cycle-type sequencer. The sequencer decides which fetch the VIC makes in each cycle; this block asks the CPU for the bus and takes it for the cycles where the VIC steals phase 2.
- Drives the BA (bus available) and AEC (address enable control) pins.
- Sits beside the sequencer in the top level, on the same phase strobes.
- Uses line position, sprite DMA enables and the badline flag to look ahead and give the CPU its 3-cycle BA warning.

Parameters:
- LOOKAHEAD, 3, number of cycles BA falls before the first stolen phase-2 access (fixed by the 6510 write window).

Ports:
- clk_dot4x  in  1  dot clock x4
- rst  in  1  reset
- clk_phi  in  1  current phi level (0 = phase 1, 1 = phase 2)
- phi_phase_start_1  in  1  one-tick strobe at each phase start
- chip  in  2  chip model (CHIP6569R1/R5, CHIP6567R56A, CHIP6567R8)
- cycle_num  in  7  0-based cycle within the raster line
- sprite_dma  in  NUM_SPRITES  per-sprite DMA enable
- badline  in  1  current line is a badline
- ba  out  1  bus available to CPU, active low = VIC requests the bus
- aec  out  1  CPU address enable, low = VIC owns the bus
- steal  out  1  current phase 2 is stolen (debug and register-file use)

Behaviour:
- Reset: reset is rst, synchronous, active-high; clock is clk_dot4x. On reset: ba=1, aec=0, steal=0, ba_cnt=0.
- Ticks:
  - bnd tick = phi_phase_start_1 && clk_phi==1. Phase 2 is ending; the new cycle begins.
  - p2 tick = phi_phase_start_1 && clk_phi==0. Phase 2 is starting.
- Line length L: 6569=63, R56A=64, R8=65. Sprite 0 base S0: 6569=57, others=58.
- Stolen cycles are defined by stolen(n):
  - Sprite s (0..7) owns cycles f=(S0+2s) mod L and (f+1) mod L. These are stolen only if sprite_dma[s]=1.
  - C-accesses own cycles 14..53 inclusive. These are stolen only if badline=1.
  - All wrap arithmetic is mod L using 8-bit intermediates; no out-of-range index is ever produced.
- req = OR of stolen((cycle_num+k) mod L) for k=0..LOOKAHEAD. It is evaluated combinationally from the current inputs.
- On each bnd tick:
  - ba <= ~req.
  - aec <= 0: phase 1 always belongs to the VIC.
  - steal <= 0.
  - ba_cnt: if req, ba_cnt <= min(ba_cnt+1, 3); otherwise ba_cnt <= 0.
- On each p2 tick:
  - If stolen(cycle_num) && ba_cnt==3: aec stays 0 and steal <= 1.
  - Otherwise aec <= 1 (CPU drives phase 2) and steal <= 0.
- The ba_cnt gate guarantees a minimum of 3 full BA-low cycles before any steal. Example: badline rising mid-window at cycle 30 gives ba=0 from cycle 30 and the first steal at cycle 33. Cycles 30-32 phase 2 go to the CPU.
- Inputs changing between ticks have no effect until the next tick.
- Line wrap: a sprite pair straddling L-1 to 0 (sprites 2/3 on R56A, 3 on R8) is handled by mod L with no gap in ba.
- Back-to-back windows: consecutive sprites, or the badline end followed by sprite 0, keep ba low continuously. ba_cnt does not reset.
- rst mid-steal forces the reset values on the next clk_dot4x edge regardless of phase.
- Latency: outputs change on the clk_dot4x edge that samples the tick (one clk_dot4x after the strobe).

Optional Feature:
- Macro: BUS_STEAL_STATS_EN.
- When defined, adds output stolen_last 7 bits plus an internal 7-bit counter.
  - The counter increments on every p2 tick where steal becomes 1.
  - On the bnd tick where cycle_num==L-1 (the line ends), stolen_last <= count (including that cycle) and the counter clears.
  - Reset value of both is 0.
- When undefined, the port and counter are absent and the behaviour is otherwise identical.

Test Plan:
- 6569, sprite_dma=8'h01, badline=0:
  - ba falls at bnd of cycle 54 and rises at bnd of cycle 59.
  - aec=0 in phase 2 of cycles 57 and 58 only.
  - steal pulses twice.
- 6569, badline=1 whole line, sprite_dma=0:
  - ba=0 for cycles 11..53.
  - aec low in phase 2 of cycles 14..53, 40 steals.
  - With BUS_STEAL_STATS_EN, stolen_last=40.
- 6569, badline rises before the bnd tick of cycle 30:
  - ba=0 at 30.
  - Phase-2 aec=1 at 30-32 and aec=0 from 33.
- R56A, sprite_dma=8'h08:
  - Steal in cycles 0 and 1.
  - ba low from cycle 61 of the previous line through cycle 1.
- R8, sprite_dma=8'hFF, badline=0:
  - ba continuously low from cycle 55 to the end of sprite 7 (cycle 8).
  - Cycle 9 is not stolen and ba=1 at the bnd tick of cycle 9.
- Assert rst during a stolen phase 2:
  - Next edge gives ba=1, aec=0, steal=0.
  - Nothing is stolen until 3 cycles after ba next falls.
